// File: rtl/mem_db_ctrl_pkg.sv
// Shared constants and helpers for the mem_db ping-pong controller.
package mem_db_ctrl_pkg;

  // mem_sw value that routes writes to bank0 and reads from bank1
  localparam logic SW_WR_BANK0 = 1'b1;

  localparam int unsigned SKID_DEPTH = 2;

  // Pointer width able to hold every address of a bank, at least one bit
  function automatic int unsigned ptr_bit(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_db_rd_skid.sv
// Two-entry fall-through FIFO for read data returning from mem_db.
// An arriving word is visible at the head in the same cycle it arrives.
module mem_db_rd_skid
  import mem_db_ctrl_pkg::*;
#(
  parameter int unsigned W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         head_valid_o,
  output logic [W-1:0] head_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [SKID_DEPTH];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         empty, store, take;

  assign empty        = (cnt_q == 2'd0);
  assign head_valid_o = !empty | push_i;
  assign head_data_o  = empty ? push_data_i : mem_q[rd_ptr_q];
  assign count_o      = cnt_q;

  // A word consumed in its arrival cycle bypasses the storage entirely
  assign store = push_i & !(empty & pop_i);
  assign take  = pop_i & !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (store) wr_ptr_q <= ~wr_ptr_q;
      if (take)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, store} - {1'b0, take};
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_db_ctrl.sv
// Ping-pong sequencer for one mem_db double buffer: the producer fills the
// write bank tile by tile while the consumer drains the read bank.
module mem_db_ctrl
  import mem_db_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BIT = 64,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_BIT = ptr_bit(DEPTH),
  parameter int unsigned TILE_LEN = DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_BIT-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data,
  output logic                out_last,
  output logic                mem_sw,
  output logic [ADDR_BIT-1:0] mem_waddr,
  output logic                mem_wen,
  output logic [DATA_BIT-1:0] mem_wdata,
  output logic [ADDR_BIT-1:0] mem_raddr,
  output logic                mem_ren,
  input  logic [DATA_BIT-1:0] mem_rdata,
  output logic [1:0]          full_cnt
);

  localparam logic [ADDR_BIT-1:0] LAST_PTR = ADDR_BIT'(TILE_LEN - 1);

  logic [ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                wr_full_q, wr_full_d, rd_full_q, rd_full_d;
  logic                sw_q, sw_d;
  logic [1:0]          full_cnt_q, full_cnt_d;
  logic                infl_q, infl_last_q;
  logic [1:0]          skid_cnt;
  logic [2:0]          occ;
  logic                wr_acc, rd_issue, swap;
  logic [DATA_BIT:0]   head_data;

  assign in_ready  = !wr_full_q;
  assign wr_acc    = in_valid & in_ready;
  assign mem_wen   = wr_acc;
  assign mem_waddr = wr_ptr_q;
  assign mem_wdata = in_data;

  // Words already buffered plus the one returning from mem_db must fit the skid
  assign occ      = {1'b0, skid_cnt} + {2'b00, infl_q};
  assign rd_issue = rd_full_q & (occ < 3'(SKID_DEPTH));
  assign mem_ren  = rd_issue;
  assign mem_raddr = rd_ptr_q;

  assign swap     = wr_full_q & !rd_full_q;
  assign mem_sw   = sw_q;
  assign full_cnt = full_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_full_d = wr_full_q;
    rd_ptr_d  = rd_ptr_q;
    rd_full_d = rd_full_q;
    sw_d      = sw_q;
    if (wr_acc) begin
      if (wr_ptr_q == LAST_PTR) begin
        wr_ptr_d  = '0;
        wr_full_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_BIT'(1);
      end
    end
    // Bank is released on its last issue; that word is still in flight
    if (rd_issue) begin
      if (rd_ptr_q == LAST_PTR) begin
        rd_ptr_d  = '0;
        rd_full_d = 1'b0;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_BIT'(1);
      end
    end
    // Swap never coincides with a write or read, so it simply overrides
    if (swap) begin
      sw_d      = !sw_q;
      rd_full_d = 1'b1;
      wr_full_d = 1'b0;
      rd_ptr_d  = '0;
    end
    full_cnt_d = {1'b0, wr_full_d} + {1'b0, rd_full_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_full_q   <= 1'b0;
      rd_full_q   <= 1'b0;
      sw_q        <= SW_WR_BANK0;
      full_cnt_q  <= 2'd0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_full_q   <= wr_full_d;
      rd_full_q   <= rd_full_d;
      sw_q        <= sw_d;
      full_cnt_q  <= full_cnt_d;
      infl_q      <= rd_issue;
      infl_last_q <= rd_issue & (rd_ptr_q == LAST_PTR);
    end
  end

  mem_db_rd_skid #(.W(DATA_BIT + 1)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (infl_q),
    .push_data_i ({infl_last_q, mem_rdata}),
    .pop_i       (out_valid & out_ready),
    .head_valid_o(out_valid),
    .head_data_o (head_data),
    .count_o     (skid_cnt)
  );

  assign out_last = head_data[DATA_BIT];
  assign out_data = head_data[DATA_BIT-1:0];

endmodule

// File: tb/tb_mem_db_ctrl.sv
// Randomized bench for mem_db_ctrl with a behavioural mem_db and an
// in-order tile scoreboard derived from the producer stream.
module tb_mem_db_ctrl;

  localparam int DW  = 64;
  localparam int DEP = 16;
  localparam int TL  = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          mem_sw;
  logic [AW-1:0] mem_waddr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    full_cnt;

  mem_db_ctrl #(.DATA_BIT(DW), .DEPTH(DEP), .ADDR_BIT(AW), .TILE_LEN(TL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mem_sw(mem_sw), .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata), .full_cnt(full_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic        sw;
    logic        last;
  } ev_t;

  ev_t wlog[$];
  ev_t rlog[$];
  ev_t got[$];
  ev_t swlog[$];
  ev_t exp_q[$];
  logic [1:0] fc_log [4096];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int outstanding = 0;
  int max_out = 0;
  logic prev_sw = 1'b1;

  logic [DW-1:0] bank0 [DEP];
  logic [DW-1:0] bank1 [DEP];
  logic          p_wen = 1'b0, p_ren = 1'b0, p_sw = 1'b1;
  logic [AW-1:0] p_waddr = '0, p_raddr = '0;
  logic [DW-1:0] p_wdata = '0;

  // Behavioural mem_db: sw=1 writes bank0 and reads bank1, one-cycle read
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (p_wen) begin
      if (p_sw) bank0[p_waddr] = p_wdata;
      else      bank1[p_waddr] = p_wdata;
    end
    if (p_ren) mem_rdata <= p_sw ? bank1[p_raddr] : bank0[p_raddr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      p_wen = 1'b0;
      p_ren = 1'b0;
      prev_sw = 1'b1;
      outstanding = 0;
    end else begin
      p_wen = mem_wen; p_waddr = mem_waddr; p_wdata = mem_wdata;
      p_ren = mem_ren; p_raddr = mem_raddr; p_sw = mem_sw;
      if (mem_wen) wlog.push_back('{cyc, mem_wdata, mem_waddr, mem_sw, 1'b0});
      if (mem_ren) begin
        rlog.push_back('{cyc, '0, mem_raddr, mem_sw, 1'b0});
        outstanding++;
      end
      if (out_valid && out_ready) begin
        got.push_back('{cyc, out_data, '0, mem_sw, out_last});
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (mem_sw !== prev_sw) begin
        swlog.push_back('{cyc, '0, '0, mem_sw, 1'b0});
        prev_sw = mem_sw;
      end
      fc_log[cyc % 4096] = full_cnt;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wlog.delete(); rlog.delete(); got.delete(); swlog.delete();
    max_out = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step(2);
    rst = 1'b1;
    clear_logs();
    exp_q.delete();
    n_acc = 0;
  endtask

  // Holds each word until accepted; every TL-th accepted word closes a tile
  task automatic push_words(input logic [DW-1:0] w[$], input int max_gap);
    int i = 0;
    int guard = 0;
    logic acc;
    while (i < w.size() && guard < 500) begin
      if (max_gap > 0) begin
        in_valid = 1'b0;
        step($urandom_range(0, max_gap));
      end
      in_valid = 1'b1;
      in_data  = w[i];
      @(negedge clk);
      acc = in_ready;
      step(1);
      if (acc) begin
        exp_q.push_back('{0, w[i], '0, 1'b0, (n_acc % TL) == TL - 1});
        n_acc++;
        i++;
        guard = 0;
      end else begin
        guard++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (i != w.size()) begin
      n_fail++;
      $display("FAIL push_timeout: accepted %0d words, required %0d", i, w.size());
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    logic [DW-1:0] w[$];
    do_reset();
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_tests++; if (mem_sw !== 1'b1) begin n_fail++; $display("FAIL rst_mem_sw: got %b required 1", mem_sw); end
    n_tests++; if (full_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_full_cnt: got %0d required 0", full_cnt); end
    step(1);
    for (int k = 0; k < 6; k++) w.push_back(rnd64());
    push_words(w, 0);
    step(3);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
    n_tests++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_mem_wen: got %b required 0", mem_wen); end
    n_tests++; if (mem_ren !== 1'b0) begin n_fail++; $display("FAIL mid_rst_mem_ren: got %b required 0", mem_ren); end
    n_tests++; if (full_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_rst_full_cnt: got %0d required 0", full_cnt); end
    n_tests++; if (mem_sw !== 1'b1) begin n_fail++; $display("FAIL mid_rst_mem_sw: got %b required 1", mem_sw); end
    step(1);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
    step(1);
    clear_logs(); exp_q.delete(); n_acc = 0;
    out_ready = 1'b1;
    step(10);
    n_tests++; if (got.size() != 0 || rlog.size() != 0) begin
      n_fail++; $display("FAIL rst_discard: got %0d words %0d reads, required 0", got.size(), rlog.size());
    end
  endtask

  task automatic test_single_tile();
    logic [DW-1:0] w[$];
    int t;
    w = '{64'h11, 64'h22, 64'h33, 64'h44};
    do_reset();
    out_ready = 1'b1;
    push_words(w, 0);
    step(12);
    n_tests++; if (wlog.size() != 4 || rlog.size() != 4 || got.size() != 4 || swlog.size() != 1) begin
      n_fail++; $display("FAIL single_counts: got w%0d r%0d o%0d s%0d required 4 4 4 1",
                         wlog.size(), rlog.size(), got.size(), swlog.size());
    end else begin
      t = wlog[0].cyc;
      for (int i = 0; i < 4; i++) begin
        n_tests++; if (wlog[i].a !== AW'(i) || wlog[i].sw !== 1'b1 || wlog[i].cyc != t + i) begin
          n_fail++; $display("FAIL single_write%0d: got addr %0d sw %b cyc %0d required %0d 1 %0d",
                             i, wlog[i].a, wlog[i].sw, wlog[i].cyc, i, t + i);
        end
        n_tests++; if (rlog[i].a !== AW'(i) || rlog[i].cyc != t + 5 + i) begin
          n_fail++; $display("FAIL single_read%0d: got addr %0d cyc %0d required %0d %0d",
                             i, rlog[i].a, rlog[i].cyc, i, t + 5 + i);
        end
        n_tests++; if (got[i].d !== exp_q[i].d || got[i].last !== (i == 3) || got[i].cyc != t + 6 + i) begin
          n_fail++; $display("FAIL single_out%0d: got %0h last %b cyc %0d required %0h %b %0d",
                             i, got[i].d, got[i].last, got[i].cyc, exp_q[i].d, i == 3, t + 6 + i);
        end
      end
      n_tests++; if (swlog[0].sw !== 1'b0 || swlog[0].cyc != t + 5) begin
        n_fail++; $display("FAIL single_swap: got sw %b cyc %0d required 0 %0d", swlog[0].sw, swlog[0].cyc, t + 5);
      end
    end
  endtask

  task automatic test_both_full();
    logic [DW-1:0] w[$];
    logic [DW-1:0] w9[$];
    do_reset();
    for (int k = 0; k < 8; k++) w.push_back(rnd64());
    push_words(w, 0);
    step(2);
    @(negedge clk);
    n_tests++; if (full_cnt !== 2'd2) begin n_fail++; $display("FAIL full_cnt_two: got %0d required 2", full_cnt); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
    step(1);
    w9.push_back(rnd64());
    in_valid = 1'b1;
    in_data  = w9[0];
    step(10);
    n_tests++; if (wlog.size() != 8) begin n_fail++; $display("FAIL full_ninth_blocked: got %0d writes required 8", wlog.size()); end
    n_tests++; if (max_out > 2) begin n_fail++; $display("FAIL full_skid_bound: got %0d required <=2", max_out); end
    out_ready = 1'b1;
    push_words(w9, 0);
    n_tests++; if (wlog.size() < 9 || swlog.size() < 2) begin
      n_fail++; $display("FAIL full_ninth_logs: got w%0d s%0d required 9 2", wlog.size(), swlog.size());
    end else if (wlog[8].cyc != swlog[1].cyc || wlog[8].sw !== 1'b1) begin
      n_fail++; $display("FAIL full_ninth_timing: got cyc %0d sw %b required %0d 1", wlog[8].cyc, wlog[8].sw, swlog[1].cyc);
    end
    w.delete();
    for (int k = 0; k < 3; k++) w.push_back(rnd64());
    push_words(w, 0);
    step(20);
    n_tests++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d required %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got[i].d !== exp_q[i].d || got[i].last !== exp_q[i].last) begin
        n_fail++; $display("FAIL full_word%0d: got %0h/%b required %0h/%b", i, got[i].d, got[i].last, exp_q[i].d, exp_q[i].last);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[$];
    w = '{64'h11, 64'h22, 64'h33, 64'h44};
    do_reset();
    fork
      push_words(w, 0);
      begin
        for (int k = 0; k < 16; k++) begin out_ready = (k % 2 == 0); step(1); end
        out_ready = 1'b1;
      end
    join
    step(10);
    n_tests++; if (max_out > 2) begin n_fail++; $display("FAIL bp_skid_bound: got %0d required <=2", max_out); end
    n_tests++; if (got.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d required 4", got.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got[i].d !== exp_q[i].d || got[i].last !== exp_q[i].last) begin
        n_fail++; $display("FAIL bp_word%0d: got %0h/%b required %0h/%b", i, got[i].d, got[i].last, exp_q[i].d, exp_q[i].last);
      end
    end
  endtask

  task automatic test_continuous();
    logic [DW-1:0] w[$];
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) w.push_back(rnd64());
    push_words(w, 0);
    step(20);
    n_tests++; if (swlog.size() != 4) begin n_fail++; $display("FAIL cont_swaps: got %0d required 4", swlog.size()); end
    for (int i = 0; i < swlog.size(); i++) begin
      n_tests++; if (swlog[i].sw !== logic'(i % 2)) begin
        n_fail++; $display("FAIL cont_sw%0d: got %b required %0d", i, swlog[i].sw, i % 2);
      end
    end
    n_tests++; if (got.size() != 16) begin n_fail++; $display("FAIL cont_count: got %0d required 16", got.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got[i].d !== exp_q[i].d || got[i].last !== exp_q[i].last) begin
        n_fail++; $display("FAIL cont_word%0d: got %0h/%b required %0h/%b", i, got[i].d, got[i].last, exp_q[i].d, exp_q[i].last);
      end
      if (i % TL != 0) begin
        n_tests++; if (got[i].cyc != got[i-1].cyc + 1) begin
          n_fail++; $display("FAIL cont_rate%0d: got cyc %0d required %0d", i, got[i].cyc, got[i-1].cyc + 1);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] w[$];
    int lw;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) w.push_back(rnd64());
    push_words(w, 0);
    step(15);
    n_tests++; if (wlog.size() != 8 || rlog.size() != 8 || swlog.size() != 2) begin
      n_fail++; $display("FAIL sim_counts: got w%0d r%0d s%0d required 8 8 2", wlog.size(), rlog.size(), swlog.size());
    end else begin
      lw = wlog[7].cyc;
      n_tests++; if (rlog[3].cyc != lw) begin
        n_fail++; $display("FAIL sim_align: got last read cyc %0d required %0d", rlog[3].cyc, lw);
      end
      n_tests++; if (swlog[1].cyc != lw + 2 || swlog[1].sw !== 1'b1) begin
        n_fail++; $display("FAIL sim_swap: got cyc %0d sw %b required %0d 1", swlog[1].cyc, swlog[1].sw, lw + 2);
      end
      for (int c = lw; c <= lw + 2; c++) begin
        n_tests++; if (fc_log[c % 4096] !== 2'd1) begin
          n_fail++; $display("FAIL sim_full_cnt%0d: got %0d required 1", c - lw, fc_log[c % 4096]);
        end
      end
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got[i].d !== exp_q[i].d || got[i].last !== exp_q[i].last) begin
        n_fail++; $display("FAIL sim_word%0d: got %0h/%b required %0h/%b", i, got[i].d, got[i].last, exp_q[i].d, exp_q[i].last);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] w[$];
    do_reset();
    for (int k = 0; k < 5 * TL; k++) w.push_back(rnd64());
    fork
      push_words(w, 2);
      begin
        for (int k = 0; k < 200; k++) begin out_ready = logic'($urandom_range(0, 1)); step(1); end
        out_ready = 1'b1;
      end
    join
    step(20);
    n_tests++; if (max_out > 2) begin n_fail++; $display("FAIL rnd_skid_bound: got %0d required <=2", max_out); end
    n_tests++; if (got.size() != 5 * TL) begin n_fail++; $display("FAIL rnd_count: got %0d required %0d", got.size(), 5 * TL); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got[i].d !== exp_q[i].d || got[i].last !== exp_q[i].last) begin
        n_fail++; $display("FAIL rnd_word%0d: got %0h/%b required %0h/%b", i, got[i].d, got[i].last, exp_q[i].d, exp_q[i].last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_both_full();
    test_backpressure();
    test_continuous();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
